iteration_controller: RTL and testbench

//  Host-facing run/terminate sequencer. It sits directly upstream of the DE4_SOPC compute system.
//  - Drives start_update to the update engine.
//  - Pulses check_terminate at a fixed interval.
//  - Compares each returned accumulated value with the previous one to detect convergence.
//  - When done, issues a DRAM flush and reports converged/timeout status.

---
 rtl/iteration_controller_if.sv | 34 +++
 rtl/iteration_controller.sv | 136 +++++++++++++
 tb/tb_iteration_controller.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/iteration_controller_if.sv
// iteration_controller_if: handshake bundle between host/compute system and iteration_controller
// Signals:
//   go, threshold                 host start pulse and convergence bound
//   accum_valid, accum_value      accumulated-value return from compute system
//   flush_done                    DRAM flush complete strobe
//   start_update, check_terminate run enable and check request to update engine
//   flush_ddr                     DRAM flush request pulse
//   busy, converged, timeout      run status
//   iter_count                    number of completed checks
interface iteration_controller_if #(
  parameter int ACC_W  = 32,
  parameter int ITER_W = 16
);
  logic              go;
  logic [ACC_W-1:0]  threshold;
  logic              accum_valid;
  logic [ACC_W-1:0]  accum_value;
  logic              flush_done;
  logic              start_update;
  logic              check_terminate;
  logic              flush_ddr;
  logic              busy;
  logic              converged;
  logic              timeout;
  logic [ITER_W-1:0] iter_count;
  modport master (
    output go, threshold, accum_valid, accum_value, flush_done,
    input  start_update, check_terminate, flush_ddr, busy, converged, timeout, iter_count
  );
  modport slave (
    input  go, threshold, accum_valid, accum_value, flush_done,
    output start_update, check_terminate, flush_ddr, busy, converged, timeout, iter_count
  );
endinterface

// File: rtl/iteration_controller.sv
// iteration_controller: run/terminate sequencer with convergence detection and DRAM flush
// Ports:
//   clk      system clock
//   reset_n  async active-low reset
//   bus      iteration_controller_if.slave (go/threshold/accum/flush_done in,
//            start_update/check_terminate/flush_ddr/busy/converged/timeout/iter_count out)
// All outputs are registered and decoded from the next state, so they line up with the state.
module iteration_controller #(
  parameter int ACC_W          = 32,
  parameter int CHECK_INTERVAL = 1000,
  parameter int MAX_ITER       = 1024,
  parameter int ACC_WAIT       = 256,
  parameter int ITER_W         = 16
) (
  input logic                   clk,
  input logic                   reset_n,
  iteration_controller_if.slave bus
);
  localparam int CW = $clog2(CHECK_INTERVAL);
  localparam int WW = $clog2(ACC_WAIT);
  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_CHECK, S_WAIT_ACC, S_EVAL, S_FLUSH, S_WAIT_FLUSH, S_DONE
  } state_t;
  state_t            r_state, w_state;
  logic [CW-1:0]     r_int, w_int;
  logic [WW-1:0]     r_wait, w_wait;
  logic [ITER_W-1:0] r_iter, w_iter;
  logic [ACC_W-1:0]  r_prev, w_prev, r_acc, w_acc;
  logic              r_first, w_first, r_conv, w_conv, r_tout, w_tout;
  logic              r_start, r_chk, r_flush, r_busy;
  logic [ACC_W:0]    w_delta;
  assign w_delta = r_acc >= r_prev ? {1'b0, r_acc - r_prev} : {1'b0, r_prev - r_acc};
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_int   <= '0;
      r_wait  <= '0;
      r_iter  <= '0;
      r_prev  <= '0;
      r_acc   <= '0;
      r_first <= 1'b0;
      r_conv  <= 1'b0;
      r_tout  <= 1'b0;
      r_start <= 1'b0;
      r_chk   <= 1'b0;
      r_flush <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_int   <= w_int;
      r_wait  <= w_wait;
      r_iter  <= w_iter;
      r_prev  <= w_prev;
      r_acc   <= w_acc;
      r_first <= w_first;
      r_conv  <= w_conv;
      r_tout  <= w_tout;
      r_start <= w_state == S_RUN;
      r_chk   <= w_state == S_CHECK;
      r_flush <= w_state == S_FLUSH;
      r_busy  <= !(w_state == S_IDLE || w_state == S_DONE);
    end
  end
  always_comb begin
    w_state = r_state;
    w_int   = r_int;
    w_wait  = r_wait;
    w_iter  = r_iter;
    w_prev  = r_prev;
    w_acc   = r_acc;
    w_first = r_first;
    w_conv  = r_conv;
    w_tout  = r_tout;
    case (r_state)
      S_IDLE, S_DONE: begin
        // DONE holds status until a new go; IDLE keeps everything cleared
        if (r_state == S_IDLE || bus.go) begin
          w_int   = '0;
          w_wait  = '0;
          w_iter  = '0;
          w_conv  = 1'b0;
          w_tout  = 1'b0;
          w_first = 1'b1;
        end
        if (bus.go) w_state = S_RUN;
      end
      S_RUN: begin
        w_int = r_int + CW'(1);
        if (r_int == CW'(CHECK_INTERVAL - 1)) begin
          w_int   = '0;
          w_state = S_CHECK;
        end
      end
      S_CHECK: w_state = S_WAIT_ACC;
      S_WAIT_ACC: begin
        // a returned value beats a simultaneous wait expiry
        if (bus.accum_valid) begin
          w_acc   = bus.accum_value;
          w_wait  = '0;
          w_state = S_EVAL;
        end else if (r_wait == WW'(ACC_WAIT - 1)) begin
          w_wait  = '0;
          w_state = S_CHECK;
        end else begin
          w_wait = r_wait + WW'(1);
        end
      end
      S_EVAL: begin
        w_prev  = r_acc;
        w_iter  = &r_iter ? r_iter : r_iter + ITER_W'(1);
        w_first = 1'b0;
        w_state = S_RUN;
        // the first value has no predecessor, so it can neither converge nor time out
        if (!r_first) begin
          if (w_delta <= {1'b0, bus.threshold}) begin
            w_conv  = 1'b1;
            w_state = S_FLUSH;
          end else if (r_iter == ITER_W'(MAX_ITER - 1)) begin
            w_tout  = 1'b1;
            w_state = S_FLUSH;
          end
        end
      end
      S_FLUSH: w_state = S_WAIT_FLUSH;
      S_WAIT_FLUSH: w_state = bus.flush_done ? S_DONE : S_WAIT_FLUSH;
      default: w_state = S_IDLE;
    endcase
  end
  assign bus.start_update    = r_start;
  assign bus.check_terminate = r_chk;
  assign bus.flush_ddr       = r_flush;
  assign bus.busy            = r_busy;
  assign bus.converged       = r_conv;
  assign bus.timeout         = r_tout;
  assign bus.iter_count      = r_iter;
endmodule

// File: tb/tb_iteration_controller.sv
// tb_iteration_controller: directed self-checking bench for iteration_controller
module tb_iteration_controller;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int total = 0;
  int bad = 0;
  int n_chk = 0;
  int n_flush = 0;
  always #5 clk = ~clk;
  iteration_controller_if #(.ACC_W(32), .ITER_W(16)) bus ();
  iteration_controller #(
    .ACC_W(32), .CHECK_INTERVAL(8), .MAX_ITER(4), .ACC_WAIT(16), .ITER_W(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );
  always @(negedge clk) begin
    if (bus.check_terminate) n_chk++;
    if (bus.flush_ddr) n_flush++;
  end
  task automatic do_reset();
    bus.go = 0; bus.threshold = 0; bus.accum_valid = 0; bus.accum_value = 0; bus.flush_done = 0;
    reset_n = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
  endtask
  task automatic pulse_go();
    bus.go = 1;
    @(negedge clk);
    bus.go = 0;
  endtask
  // returns the number of cycles until check_terminate is seen high
  task automatic wait_chk(input string nm, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.check_terminate && n < 100);
    if (!bus.check_terminate) begin
      total++; bad++;
      $display("FAIL %s: no check_terminate within 100 cycles", nm);
    end
  endtask
  // called in the CHECK cycle; returns one cycle after EVAL
  task automatic feed(input logic [31:0] v);
    @(negedge clk);
    bus.accum_valid = 1; bus.accum_value = v;
    @(negedge clk);
    bus.accum_valid = 0;
    @(negedge clk);
  endtask
  // called in the FLUSH cycle; returns in DONE
  task automatic finish_flush();
    @(negedge clk);
    bus.flush_done = 1;
    @(negedge clk);
    bus.flush_done = 0;
  endtask
  task automatic test_reset();
    do_reset();
    total++;
    if ({bus.start_update, bus.check_terminate, bus.flush_ddr, bus.busy, bus.converged, bus.timeout} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 000000",
        {bus.start_update, bus.check_terminate, bus.flush_ddr, bus.busy, bus.converged, bus.timeout});
    end
    total++;
    if (bus.iter_count !== 16'd0) begin bad++; $display("FAIL reset_iter: got %0d want 0", bus.iter_count); end
  endtask
  task automatic test_reset_mid_run();
    do_reset();
    pulse_go();
    repeat (3) @(negedge clk);
    total++;
    if (bus.start_update !== 1'b1) begin bad++; $display("FAIL mid_run_active: start_update=%b want 1", bus.start_update); end
    #2 reset_n = 0;
    #1;
    total++;
    if ({bus.start_update, bus.check_terminate, bus.flush_ddr, bus.busy, bus.converged, bus.timeout} !== 6'b0 || bus.iter_count !== 16'd0) begin
      bad++;
      $display("FAIL async_reset: flags=%b iter=%0d want all zero",
        {bus.start_update, bus.check_terminate, bus.flush_ddr, bus.busy, bus.converged, bus.timeout}, bus.iter_count);
    end
    @(negedge clk);
    reset_n = 1;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.start_update, bus.busy} !== 2'b00) begin bad++; $display("FAIL idle_after_reset: start/busy=%b want 00", {bus.start_update, bus.busy}); end
    pulse_go();
    total++;
    if (bus.start_update !== 1'b1) begin bad++; $display("FAIL restart_after_reset: start_update=%b want 1", bus.start_update); end
  endtask
  task automatic test_converge();
    int n, c0, f0;
    do_reset();
    bus.threshold = 32'd5;
    c0 = n_chk; f0 = n_flush;
    pulse_go();
    total++;
    if ({bus.start_update, bus.busy} !== 2'b11) begin bad++; $display("FAIL conv_go_latency: start/busy=%b want 11", {bus.start_update, bus.busy}); end
    wait_chk("conv_chk1", n);
    total++;
    if (n !== 8) begin bad++; $display("FAIL conv_gap1: got %0d want 8", n); end
    total++;
    if (bus.start_update !== 1'b0) begin bad++; $display("FAIL conv_start_low_in_check: got %b want 0", bus.start_update); end
    feed(32'd100);
    total++;
    if ({bus.start_update, bus.iter_count} !== {1'b1, 16'd1}) begin bad++; $display("FAIL conv_eval1: start=%b iter=%0d want 1/1", bus.start_update, bus.iter_count); end
    wait_chk("conv_chk2", n);
    total++;
    if (n !== 8) begin bad++; $display("FAIL conv_gap2: got %0d want 8", n); end
    feed(32'd150);
    total++;
    if ({bus.start_update, bus.converged} !== 2'b10) begin bad++; $display("FAIL conv_eval2: start/conv=%b want 10", {bus.start_update, bus.converged}); end
    wait_chk("conv_chk3", n);
    total++;
    if (n !== 8) begin bad++; $display("FAIL conv_gap3: got %0d want 8", n); end
    feed(32'd152);
    total++;
    if ({bus.flush_ddr, bus.converged, bus.start_update, bus.busy} !== 4'b1101) begin
      bad++; $display("FAIL conv_flush: flush/conv/start/busy=%b want 1101", {bus.flush_ddr, bus.converged, bus.start_update, bus.busy});
    end
    finish_flush();
    #1;
    total++;
    if ({bus.busy, bus.converged, bus.timeout} !== 3'b010) begin bad++; $display("FAIL conv_done: busy/conv/tout=%b want 010", {bus.busy, bus.converged, bus.timeout}); end
    total++;
    if (bus.iter_count !== 16'd3) begin bad++; $display("FAIL conv_iter: got %0d want 3", bus.iter_count); end
    total++;
    if (n_chk - c0 !== 3) begin bad++; $display("FAIL conv_chk_count: got %0d want 3", n_chk - c0); end
    total++;
    if (n_flush - f0 !== 1) begin bad++; $display("FAIL conv_flush_count: got %0d want 1", n_flush - f0); end
  endtask
  task automatic test_timeout();
    int n;
    do_reset();
    bus.threshold = 32'd10;
    pulse_go();
    for (int i = 0; i < 4; i++) begin
      wait_chk("tout_chk", n);
      feed(i % 2 == 1 ? 32'd1000 : 32'd0);
      if (i < 3) begin
        total++;
        if ({bus.start_update, bus.timeout} !== 2'b10) begin bad++; $display("FAIL tout_eval%0d: start/tout=%b want 10", i, {bus.start_update, bus.timeout}); end
      end else begin
        total++;
        if ({bus.flush_ddr, bus.timeout, bus.converged} !== 3'b110) begin bad++; $display("FAIL tout_flush: flush/tout/conv=%b want 110", {bus.flush_ddr, bus.timeout, bus.converged}); end
      end
    end
    finish_flush();
    total++;
    if ({bus.busy, bus.timeout, bus.converged} !== 3'b010 || bus.iter_count !== 16'd4) begin
      bad++; $display("FAIL tout_done: busy/tout/conv=%b iter=%0d want 010/4", {bus.busy, bus.timeout, bus.converged}, bus.iter_count);
    end
  endtask
  task automatic test_missing_ack();
    int n, c0;
    do_reset();
    bus.threshold = 32'd0;
    c0 = n_chk;
    pulse_go();
    wait_chk("ack_chk1", n);
    // 16 WAIT_ACC cycles, then the re-pulse in the following CHECK cycle
    wait_chk("ack_chk2", n);
    total++;
    if (n !== 17) begin bad++; $display("FAIL ack_repulse1: got %0d want 17", n); end
    wait_chk("ack_chk3", n);
    total++;
    if (n !== 17) begin bad++; $display("FAIL ack_repulse2: got %0d want 17", n); end
    #1;
    total++;
    if (n_chk - c0 !== 3 || bus.iter_count !== 16'd0 || bus.start_update !== 1'b0) begin
      bad++; $display("FAIL ack_waiting: chks=%0d iter=%0d start=%b want 3/0/0", n_chk - c0, bus.iter_count, bus.start_update);
    end
    feed(32'd77);
    total++;
    if ({bus.start_update, bus.iter_count} !== {1'b1, 16'd1}) begin bad++; $display("FAIL ack_late_accept: start=%b iter=%0d want 1/1", bus.start_update, bus.iter_count); end
  endtask
  task automatic test_abs_boundary();
    int n;
    do_reset();
    bus.threshold = 32'hFFFF_FFE0;
    pulse_go();
    wait_chk("abs_chk1", n);
    feed(32'hFFFF_FFF0);
    wait_chk("abs_chk2", n);
    feed(32'h0000_0010);
    total++;
    if ({bus.flush_ddr, bus.converged} !== 2'b11) begin bad++; $display("FAIL abs_wide_delta: flush/conv=%b want 11", {bus.flush_ddr, bus.converged}); end
    finish_flush();
    bus.threshold = 32'd5;
    pulse_go();
    total++;
    if ({bus.converged, bus.busy, bus.iter_count} !== {2'b01, 16'd0}) begin
      bad++; $display("FAIL abs_go_in_done: conv/busy=%b iter=%0d want 01/0", {bus.converged, bus.busy}, bus.iter_count);
    end
    wait_chk("abs_chk3", n);
    feed(32'd10);
    wait_chk("abs_chk4", n);
    feed(32'd4);
    total++;
    if ({bus.start_update, bus.converged, bus.flush_ddr} !== 3'b100 || bus.iter_count !== 16'd2) begin
      bad++; $display("FAIL abs_delta6: start/conv/flush=%b iter=%0d want 100/2", {bus.start_update, bus.converged, bus.flush_ddr}, bus.iter_count);
    end
    wait_chk("abs_chk5", n);
    feed(32'd4);
    total++;
    if ({bus.converged, bus.iter_count} !== {1'b1, 16'd3}) begin bad++; $display("FAIL abs_delta0: conv=%b iter=%0d want 1/3", bus.converged, bus.iter_count); end
    finish_flush();
  endtask
  task automatic test_ignored_inputs();
    int n, c0, f0;
    do_reset();
    bus.threshold = 32'd3;
    c0 = n_chk; f0 = n_flush;
    pulse_go();
    repeat (2) @(negedge clk);
    bus.go = 1; bus.accum_valid = 1; bus.accum_value = 32'd9; bus.flush_done = 1;
    @(negedge clk);
    bus.go = 0; bus.accum_valid = 0; bus.flush_done = 0;
    wait_chk("ign_chk1", n);
    total++;
    if (n !== 5) begin bad++; $display("FAIL ign_interval: got %0d want 5", n); end
    #1;
    total++;
    if (n_chk - c0 !== 1 || n_flush - f0 !== 0 || bus.iter_count !== 16'd0) begin
      bad++; $display("FAIL ign_no_extra: chks=%0d flushes=%0d iter=%0d want 1/0/0", n_chk - c0, n_flush - f0, bus.iter_count);
    end
    feed(32'd5);
    wait_chk("ign_chk2", n);
    feed(32'd5);
    total++;
    if ({bus.flush_ddr, bus.converged} !== 2'b11) begin bad++; $display("FAIL ign_converge: flush/conv=%b want 11", {bus.flush_ddr, bus.converged}); end
    finish_flush();
    total++;
    if ({bus.busy, bus.converged, bus.iter_count} !== {2'b01, 16'd2}) begin
      bad++; $display("FAIL ign_done: busy/conv=%b iter=%0d want 01/2", {bus.busy, bus.converged}, bus.iter_count);
    end
    pulse_go();
    total++;
    if ({bus.start_update, bus.busy, bus.converged, bus.timeout, bus.iter_count} !== {4'b1100, 16'd0}) begin
      bad++; $display("FAIL ign_restart: start/busy/conv/tout=%b iter=%0d want 1100/0",
        {bus.start_update, bus.busy, bus.converged, bus.timeout}, bus.iter_count);
    end
  endtask
  initial begin
    test_reset();
    test_reset_mid_run();
    test_converge();
    test_timeout();
    test_missing_ack();
    test_abs_boundary();
    test_ignored_inputs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
